// File: rtl/reg_bus_master.sv
// Host byte-stream to register-bus bridge: decodes 'W' addr data / 'R' addr commands,
// drives addr/data_out/we and returns one response byte per command.
module reg_bus_master #(
    parameter int DATA_WIDTH     = 8,
    parameter int RD_LATENCY     = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  we,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  busy,
    output logic [7:0]            err_count
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DATA_WIDTH-1:0] OP_WR   = DATA_WIDTH'(8'h57);
    localparam logic [DATA_WIDTH-1:0] OP_RD   = DATA_WIDTH'(8'h52);
    localparam logic [DATA_WIDTH-1:0] RSP_OK  = DATA_WIDTH'(8'h4B);
    localparam logic [DATA_WIDTH-1:0] RSP_BAD = DATA_WIDTH'(8'h3F);
    localparam logic [TW-1:0]         TO_MAX  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, WRITE, RD_WAIT, SEND
    } state_t;

    state_t                state, state_n;
    logic                  op_rd, op_rd_n;
    logic [DATA_WIDTH-1:0] addr_n, data_n, tx_data_n;
    logic [3:0]            rd_cnt, rd_cnt_n;
    logic [TW-1:0]         to_cnt, to_cnt_n;
    logic                  err_inc;

    always_comb begin
        state_n   = state;
        op_rd_n   = op_rd;
        addr_n    = addr;
        data_n    = data_out;
        tx_data_n = tx_data;
        rd_cnt_n  = rd_cnt;
        to_cnt_n  = to_cnt;
        err_inc   = 1'b0;
        case (state)
            IDLE: begin
                to_cnt_n = '0;
                if (rx_valid) begin
                    if (rx_data == OP_WR) begin
                        op_rd_n = 1'b0;
                        state_n = GET_ADDR;
                    end else if (rx_data == OP_RD) begin
                        op_rd_n = 1'b1;
                        state_n = GET_ADDR;
                    end else begin
                        tx_data_n = RSP_BAD;
                        err_inc   = 1'b1;
                        state_n   = SEND;
                    end
                end
            end
            GET_ADDR: begin
                if (rx_valid) begin
                    addr_n   = rx_data;
                    to_cnt_n = '0;
                    if (op_rd) begin
                        rd_cnt_n = 4'(RD_LATENCY);
                        state_n  = RD_WAIT;
                    end else begin
                        state_n  = GET_DATA;
                    end
                end else if (to_cnt == TO_MAX) begin
                    to_cnt_n = '0;
                    err_inc  = 1'b1;
                    state_n  = IDLE;
                end else begin
                    to_cnt_n = to_cnt + 1'b1;
                end
            end
            GET_DATA: begin
                if (rx_valid) begin
                    data_n   = rx_data;
                    to_cnt_n = '0;
                    state_n  = WRITE;
                end else if (to_cnt == TO_MAX) begin
                    to_cnt_n = '0;
                    err_inc  = 1'b1;
                    state_n  = IDLE;
                end else begin
                    to_cnt_n = to_cnt + 1'b1;
                end
            end
            WRITE: begin
                tx_data_n = RSP_OK;
                state_n   = SEND;
            end
            RD_WAIT: begin
                // rd_cnt==1 here means this edge is the RD_LATENCY-th since addr load
                if (rd_cnt <= 4'd1) begin
                    tx_data_n = bus_rdata;
                    state_n   = SEND;
                end else begin
                    rd_cnt_n = rd_cnt - 4'd1;
                end
            end
            SEND: begin
                if (tx_valid && tx_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Bytes arriving while a command is executing are dropped
        if (rx_valid && (state == WRITE || state == RD_WAIT || state == SEND))
            err_inc = 1'b1;
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state     <= IDLE;
            op_rd     <= 1'b0;
            addr      <= '0;
            data_out  <= '0;
            tx_data   <= '0;
            rd_cnt    <= '0;
            to_cnt    <= '0;
            we        <= 1'b0;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            err_count <= '0;
        end else begin
            state    <= state_n;
            op_rd    <= op_rd_n;
            addr     <= addr_n;
            data_out <= data_n;
            tx_data  <= tx_data_n;
            rd_cnt   <= rd_cnt_n;
            to_cnt   <= to_cnt_n;
            // Strobes are registered from the next state so they align with it
            we       <= (state_n == WRITE);
            tx_valid <= (state_n == SEND);
            busy     <= (state_n != IDLE);
            if (err_inc && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_reg_bus_master.sv
// Randomized bench for reg_bus_master: command-level model with a memory-backed slave
// that only presents correct read data on the exact expected sampling edge.
module tb_reg_bus_master;
    localparam int DW = 8;
    localparam int RL = 2;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          res;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] addr;
    logic [DW-1:0] data_out;
    logic          we;
    logic [DW-1:0] bus_rdata;
    logic          busy;
    logic [7:0]    err_count;

    reg_bus_master #(.DATA_WIDTH(DW), .RD_LATENCY(RL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .res(res), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .addr(addr), .data_out(data_out), .we(we), .bus_rdata(bus_rdata),
        .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  smem [256];
    logic [7:0]  mmem [256];
    int unsigned cyc   = 0;
    int unsigned rd_at = 32'hFFFF_FFFF;
    int          we_cnt = 0;
    logic [7:0]  we_a, we_d;
    int          mdl_err = 0;
    logic [7:0]  mdl_addr = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;
    // Correct data only on the edge where the sample is due; inverted otherwise
    assign bus_rdata = (cyc == rd_at) ? smem[addr] : ~smem[addr];
    always @(posedge clk) if (we) smem[addr] <= data_out;
    always @(negedge clk) if (we) begin we_cnt++; we_a = addr; we_d = data_out; end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic send_byte(input logic [7:0] b, output int unsigned c0);
        @(negedge clk); rx_data = b; rx_valid = 1'b1;
        @(negedge clk); rx_valid = 1'b0;
        c0 = cyc - 1;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic get_resp(input logic [7:0] exp, input int hold, input bit inject, input string tag);
        int t = 0;
        while (!tx_valid && t < 30) begin @(negedge clk); t++; end
        if (!tx_valid) begin chk({tag, "_timeout"}, 32'd0, 32'd1); return; end
        chk({tag, "_data"}, 32'(tx_data), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            if (inject && i == 0) begin
                rx_data = 8'($urandom); rx_valid = 1'b1; mdl_err = sat(mdl_err + 1);
            end
            @(negedge clk); rx_valid = 1'b0;
            chk({tag, "_hold"}, {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, exp});
        end
        tx_ready = 1'b1; @(negedge clk); tx_ready = 1'b0;
        chk({tag, "_done"}, {30'd0, tx_valid, busy}, 32'd0);
    endtask

    task automatic post_chk(input string tag);
        chk({tag, "_err"}, 32'(err_count), 32'(mdl_err));
        chk({tag, "_addr"}, 32'(addr), 32'(mdl_addr));
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int hold, input bit inject);
        int unsigned c;
        int w0 = we_cnt;
        send_byte(8'h57, c); gap($urandom_range(0, 3));
        send_byte(a, c);     gap($urandom_range(0, 3));
        send_byte(d, c);
        mmem[a] = d; mdl_addr = a;
        get_resp(8'h4B, hold, inject, "wr");
        chk("wr_we_cnt", 32'(we_cnt), 32'(w0 + 1));
        chk("wr_we_addr_data", {16'd0, we_a, we_d}, {16'd0, a, d});
        post_chk("wr");
    endtask

    task automatic do_read(input logic [7:0] a, input int hold, input bit inject);
        int unsigned c;
        send_byte(8'h52, c); gap($urandom_range(0, 3));
        send_byte(a, c);
        rd_at = c + RL; mdl_addr = a;
        get_resp(mmem[a], hold, inject, "rd");
        post_chk("rd");
    endtask

    task automatic do_bad(input logic [7:0] op, input int hold, input bit inject);
        int unsigned c;
        send_byte(op, c);
        mdl_err = sat(mdl_err + 1);
        get_resp(8'h3F, hold, inject, "bad");
        post_chk("bad");
    endtask

    initial begin
        int unsigned c;
        bit tv;
        int w0;
        logic [7:0] op;
        res = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            smem[i] = 8'($urandom); mmem[i] = smem[i];
        end
        smem[8'h22] = 8'hA5; mmem[8'h22] = 8'hA5;
        gap(3);
        chk("reset_outs", {tx_data, addr, data_out, err_count}, 32'd0);
        chk("reset_strobes", {29'd0, we, tx_valid, busy}, 32'd0);
        @(negedge clk); res = 1'b0;

        // directed: read with exact latency, write, bad opcode with backpressure, overrun
        do_read(8'h22, 0, 0);
        do_write(8'h22, 8'h05, 1, 0);
        do_bad(8'h13, 10, 0);
        do_bad(8'h13, 4, 1);

        // timeout with command partially received
        w0 = we_cnt; tv = 1'b0;
        send_byte(8'h57, c); send_byte(8'h20, c);
        mdl_addr = 8'h20;
        repeat (TO - 1) begin @(negedge clk); tv |= tx_valid; end
        chk("to_busy_mid", 32'(busy), 32'd1);
        @(negedge clk); tv |= tx_valid;
        chk("to_busy_end", 32'(busy), 32'd0);
        chk("to_no_tx_we", {31'd0, tv}, 32'(we_cnt - w0));
        mdl_err = sat(mdl_err + 1);
        post_chk("to");
        do_read(8'h20, 1, 0);

        // saturation via overrun while a response is pending
        send_byte(8'h13, c);
        mdl_err = sat(mdl_err + 1);
        rx_valid = 1'b1; rx_data = 8'h55;
        repeat (300) @(negedge clk);
        rx_valid = 1'b0;
        mdl_err = sat(mdl_err + 300);
        chk("sat_err", 32'(err_count), 32'hFF);
        get_resp(8'h3F, 0, 0, "sat");

        // reset mid-read, then reset with a pending response
        send_byte(8'h52, c); send_byte(8'h22, c);
        #2 res = 1'b1;
        #1 chk("rst_rd", {tx_valid, busy, 6'd0, addr, err_count, 8'd0}, 32'd0);
        @(negedge clk); res = 1'b0;
        mdl_err = 0; mdl_addr = 8'h00;
        send_byte(8'h33, c);
        @(negedge clk);
        chk("rst_send_pre", 32'(tx_valid), 32'd1);
        #2 res = 1'b1;
        #1 chk("rst_send", {30'd0, tx_valid, busy}, 32'd0);
        @(negedge clk); res = 1'b0;
        do_write(8'h21, 8'h3C, 0, 0);

        // randomized command mix
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 2))
                0: do_write(8'($urandom), 8'($urandom), $urandom_range(0, 3), 1'($urandom));
                1: do_read(8'($urandom), $urandom_range(0, 3), 1'($urandom));
                default: begin
                    op = 8'($urandom);
                    while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
                    do_bad(op, $urandom_range(0, 3), 1'($urandom));
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
